// File: rtl/lc3_mmio_ctrl.sv
// rtl/lc3_mmio_ctrl.sv - LC-3 memory-mapped keyboard/display controller with interrupt pulse generator
//
// Purpose:
//   Decodes KBSR/KBDR/DSR/DDR on the CPU data bus, buffers keyboard characters
//   in a small FIFO, holds one pending display character for an output sink,
//   and drives the CPU's active-low irq line with a fixed-width pulse per event.
//
// Ports:
//   clk                  system clock, all state changes on posedge
//   reset                asynchronous active-low reset
//   MA, md_wdata, we, rd bus address, write data, write strobe, read strobe
//   md_rdata, sel        combinational read data and register-hit flag
//   kb_valid/kb_data/kb_ready     keyboard source handshake
//   dsp_valid/dsp_data/dsp_ready  display sink handshake
//   irq                  active-low interrupt request
module lc3_mmio_ctrl #(
  parameter int          KB_DEPTH  = 4,
  parameter int          IRQ_PULSE = 2,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] MA,
  input  logic [15:0] md_wdata,
  input  logic        we,
  input  logic        rd,
  output logic [15:0] md_rdata,
  output logic        sel,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        irq
);

  localparam int PW   = $clog2(KB_DEPTH);
  localparam int CW   = $clog2(KB_DEPTH + 1);
  localparam int CNTW = (IRQ_PULSE > 1) ? $clog2(IRQ_PULSE) : 1;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_HOLD   = 2'd2
  } irq_state_e;

  // Keyboard FIFO
  logic [7:0]    mem_q [KB_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_prev_q;
  logic          empty, full, push, pop;
  logic [7:0]    kb_head;

  // Control / display registers
  logic          kb_ie_q, kb_ie_d;
  logic          ds_ie_q, ds_ie_d;
  logic          dsp_valid_q, dsp_valid_d;
  logic [7:0]    dsp_data_q, dsp_data_d;

  // Interrupt generator
  logic            cond, cond_q;
  irq_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{md_wdata[15], md_wdata[13:8]};

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(KB_DEPTH));
  assign kb_ready = ~full;
  assign push     = kb_valid & ~full;
  // Pop only on the first cycle of a read strobe so a multi-cycle read
  // consumes exactly one character.
  assign pop      = rd & ~rd_prev_q & (MA == KBDR_ADDR) & ~empty;
  assign kb_head  = empty ? 8'h00 : mem_q[rd_ptr_q];

  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;

  // Combinational read decode
  always_comb begin
    md_rdata = 16'h0000;
    sel      = 1'b0;
    case (MA)
      KBSR_ADDR: begin
        sel      = 1'b1;
        md_rdata = {~empty, kb_ie_q, 14'b0};
      end
      KBDR_ADDR: begin
        sel      = 1'b1;
        md_rdata = {8'b0, kb_head};
      end
      DSR_ADDR: begin
        sel      = 1'b1;
        md_rdata = {~dsp_valid_q, ds_ie_q, 14'b0};
      end
      DDR_ADDR: begin
        sel      = 1'b1;
        md_rdata = {8'b0, dsp_data_q};
      end
      default: ;
    endcase
  end

  // FIFO pointer / count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Register writes and display handshake
  always_comb begin
    kb_ie_d     = kb_ie_q;
    ds_ie_d     = ds_ie_q;
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    if (we) begin
      case (MA)
        KBSR_ADDR: kb_ie_d = md_wdata[14];
        DSR_ADDR:  ds_ie_d = md_wdata[14];
        DDR_ADDR: begin
          // A write while a character is pending is dropped, which also
          // keeps it from colliding with a same-cycle sink transfer.
          if (!dsp_valid_q) begin
            dsp_data_d  = md_wdata[7:0];
            dsp_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (dsp_valid_q && dsp_ready) dsp_valid_d = 1'b0;
  end

  assign cond = (kb_ie_q & ~empty) | (ds_ie_q & ~dsp_valid_q);

  // IRQ FSM next state. IDLE is only entered from reset or from HOLD with
  // cond_q==0, so seeing cond_q==1 in IDLE is exactly a 0->1 rise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq     = 1'b1;
    case (state_q)
      IRQ_IDLE: begin
        if (cond_q) begin
          state_d = IRQ_ASSERT;
          cnt_d   = CNTW'(IRQ_PULSE - 1);
        end
      end
      IRQ_ASSERT: begin
        irq = 1'b0;
        if (cnt_q == '0) state_d = IRQ_HOLD;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      IRQ_HOLD: begin
        if (!cond_q) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_prev_q   <= 1'b0;
      kb_ie_q     <= 1'b0;
      ds_ie_q     <= 1'b0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 8'h00;
      cond_q      <= 1'b0;
      state_q     <= IRQ_IDLE;
      cnt_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_prev_q   <= rd;
      kb_ie_q     <= kb_ie_d;
      ds_ie_q     <= ds_ie_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
      cond_q      <= cond;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= kb_data;
  end

endmodule
